load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//  CPU-side initiator for the byte-wide data memory bus. Accepts one load/store per
//  request (RV32 func3 encoding), serialises it into 1/2/4 byte beats over a req/ack
//  bus, and assembles the load result with sign/zero extension. It sits between the
//  execute stage and a byte-organised data memory (a multi-cycle bus responder).
// PARAMETERS
//  ADDR_W    10   memory byte-address width; memAddr wraps modulo 2**ADDR_W
//  MAX_WAIT  15   max consecutive cycles with memReq=1 and no memAck before abort
// PORTS
//  clk        in   1       clock, rising edge
//  rst_n      in   1       asynchronous, active-low reset
//  start      in   1       request strobe; sampled only in IDLE
//  memRead    in   1       load request (exactly one of memRead/memWrite must be 1)
//  memWrite   in   1       store request
//  func3      in   3       000 b, 001 h, 010 w, 100 bu, 101 hu
//  aluOut     in   32      byte address; only [ADDR_W-1:0] used
//  data2      in   32      store data, little-endian byte lanes
//  busy       out  1       high from cycle after accept through the done cycle
//  done       out  1       one-cycle completion pulse
//  accessErr  out  1       valid with done: misaligned/illegal/timeout
//  memData    out  32      load result; valid from done until next accept
//  memReq     out  1       bus request, held until memAck
//  memWe      out  1       1 = write beat
//  memAddr    out  ADDR_W  beat byte address
//  memWdata   out  8       write byte
//  memRdata   in   8       read byte, sampled when memReq && memAck
//  memAck     in   1       beat complete; ignored when memReq=0
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, beat/wait counters 0; asserted mid-transfer,
//   memReq drops immediately and the transfer is discarded.
//  FSM: IDLE -> ISSUE -> DONE -> IDLE; IDLE -> DONE directly on error check.
//  IDLE: start && (memRead ^ memWrite) accepts and latches addr/data/func3/dir.
//   start with both or neither of memRead/memWrite: ignored, no response.
//   Size: 000/100 -> 1, 001/101 -> 2, 010 -> 4 beats.
//   Illegal: func3 011/110/111, or 100/101 with memWrite -> DONE, accessErr=1.
//   Misaligned (h with addr[0]=1, w with addr[1:0]!=0): see CONFIGURATION.
//   On error: no bus activity, memData=0.
//  ISSUE: memReq=1, memAddr=base+beat (mod 2**ADDR_W), memWe=dir,
//   memWdata=data2[8*beat+:8]. Hold all bus outputs stable until memAck=1.
//   memAck in the same cycle memReq rises is legal (zero-wait).
//   On ack: a read captures memRdata into byte lane beat; the last beat goes to DONE;
//   otherwise beat++ and the next beat is presented the following cycle.
//   Wait counter clears on each ack; reaching MAX_WAIT aborts to DONE with
//   accessErr=1 and memData=0.
//  DONE: done=1 for one cycle; memData = lw raw | lh/lb sign-ext | lhu/lbu zero-ext;
//   stores give memData=0. Returns to IDLE; start in the DONE cycle is ignored.
//  Latency with zero-wait ack (accept at T): byte done T+2, half T+3, word T+5.
//  Error/abort done is one cycle after detection.
// CONFIGURATION
//  LSU_MISALIGNED_SPLIT_EN defined: misaligned h/w run as normal byte beats at
//   base..base+size-1 (address wraps), with no error.
//  Undefined: misaligned h/w -> DONE with accessErr=1, no bus beats.
// TESTING
//  sw 0xA1B2C3D4 @0x010, zero-wait ack -> beats 0x010..0x013 carry D4,C3,B2,A1;
//   done at T+5; accessErr=0.
//  lb @0x011 with memRdata=0x80 -> memData=0xFFFFFF80; lbu -> 0x00000080.
//  lh @0x3FE returning 0x34,0x92 with 2 wait cycles per beat -> memData=0xFFFF9234,
//   done at T+7.
//  lw @0x002: macro off -> accessErr=1, memReq never rises; macro on -> addresses
//   0x002..0x005 are issued.
//  lw @0x3FE, macro on -> memAddr sequence 0x3FE,0x3FF,0x000,0x001.
//  memAck held 0 -> abort after 15 wait cycles, accessErr=1; rst_n low mid-word
//   -> memReq=0 asynchronously; start with memRead=memWrite=1 -> no busy/done.

Source files
------------

// File: rtl/load_store_unit.sv
// Byte-serial load/store initiator: splits b/h/w accesses into req/ack byte beats and extends loads.
// Optional macro LSU_MISALIGNED_SPLIT_EN lets misaligned h/w run as byte beats instead of erroring.
module load_store_unit #(
    parameter int ADDR_W   = 10,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic [2:0]        func3,
    input  logic [31:0]       aluOut,
    input  logic [31:0]       data2,
    output logic              busy,
    output logic              done,
    output logic              accessErr,
    output logic [31:0]       memData,
    output logic              memReq,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [7:0]        memWdata,
    input  logic [7:0]        memRdata,
    input  logic              memAck
);
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [2:0]        f3_q, f3_d;
    logic              we_q, we_d;
    logic [1:0]        beat_q, beat_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [31:0]       rbuf_q, rbuf_d;
    logic              err_q, err_d;
    logic [31:0]       mem_data_q, mem_data_d;

    logic              illegal, misaligned, req_err;
    logic [1:0]        last_beat;

    logic unused_addr_hi;
    assign unused_addr_hi = ^aluOut[31:ADDR_W];

    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [31:0] raw);
        logic [31:0] r;
        case (f3[1:0])
            2'b00:   r = {{24{raw[7]  & ~f3[2]}}, raw[7:0]};
            2'b01:   r = {{16{raw[15] & ~f3[2]}}, raw[15:0]};
            default: r = raw;
        endcase
        return r;
    endfunction

    always_comb begin
        illegal    = (func3 == 3'b011) || (func3[2:1] == 2'b11) || (func3[2] && memWrite);
        misaligned = ((func3[1:0] == 2'b01) && aluOut[0]) ||
                     ((func3[1:0] == 2'b10) && (aluOut[1:0] != 2'b00));
`ifdef LSU_MISALIGNED_SPLIT_EN
        req_err    = illegal;
`else
        req_err    = illegal || misaligned;
`endif
        last_beat  = f3_q[1] ? 2'd3 : (f3_q[0] ? 2'd1 : 2'd0);
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        f3_d       = f3_q;
        we_d       = we_q;
        beat_d     = beat_q;
        wait_d     = wait_q;
        rbuf_d     = rbuf_q;
        err_d      = err_q;
        mem_data_d = mem_data_q;
        case (state_q)
            S_IDLE: begin
                if (start && (memRead ^ memWrite)) begin
                    addr_d     = aluOut[ADDR_W-1:0];
                    wdata_d    = data2;
                    f3_d       = func3;
                    we_d       = memWrite;
                    beat_d     = 2'd0;
                    wait_d     = '0;
                    rbuf_d     = '0;
                    mem_data_d = '0;
                    err_d      = req_err;
                    state_d    = req_err ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (memAck) begin
                    if (!we_q) rbuf_d[8*beat_q +: 8] = memRdata;
                    wait_d = '0;
                    if (beat_q == last_beat) begin
                        state_d    = S_DONE;
                        mem_data_d = we_q ? 32'd0 : load_ext(f3_q, rbuf_d);
                    end else begin
                        beat_d = beat_q + 2'd1;
                    end
                end else if (wait_q == WAIT_W'(MAX_WAIT - 1)) begin
                    // bus never answered: abandon the transfer
                    state_d    = S_DONE;
                    err_d      = 1'b1;
                    mem_data_d = '0;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            f3_q       <= '0;
            we_q       <= 1'b0;
            beat_q     <= '0;
            wait_q     <= '0;
            rbuf_q     <= '0;
            err_q      <= 1'b0;
            mem_data_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            f3_q       <= f3_d;
            we_q       <= we_d;
            beat_q     <= beat_d;
            wait_q     <= wait_d;
            rbuf_q     <= rbuf_d;
            err_q      <= err_d;
            mem_data_q <= mem_data_d;
        end
    end

    // bus outputs decode straight from state so reset drops memReq without a clock
    always_comb begin
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
        accessErr = done && err_q;
        memData   = mem_data_q;
        memReq    = (state_q == S_ISSUE);
        memWe     = memReq && we_q;
        memAddr   = memReq ? (addr_q + ADDR_W'(beat_q)) : '0;
        memWdata  = memReq ? wdata_q[8*beat_q +: 8] : 8'd0;
    end
endmodule
